// File: rtl/tm_shell_pkg.sv
// Shared types for the slave-side tag-return shell: the per-request context
// stripped on entry and re-attached to the matching response.
package tm_shell_pkg;
   localparam int unsigned TAG_W  = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned VC_W   = 2;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] src;
      logic [VC_W-1:0]   vc;
   } tm_ctx_t;

   localparam int unsigned CTX_W = $bits(tm_ctx_t);
endpackage

// File: rtl/tm_ctx_fifo.sv
// Synchronous show-ahead context FIFO; pointers wrap modulo DEPTH so any
// depth >= 2 is legal. Push is ignored when full, pop is ignored when empty.
module tm_ctx_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 14,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok_s, pop_ok_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return ptr + PTR_W'(1);
      end
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == {CNT_W{1'b0}});
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // Full/empty use registered state only, so there is no bypass at either bound
   always_comb begin
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      wr_ptr_d  = push_ok_s ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop_ok_s  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end
endmodule

// File: rtl/tm_slave_multimaster_tag_return.sv
// Slave-side credit shell: stores {tag,src,vc} of each accepted request and
// re-attaches it, in order, to the next response from the in-order slave.
module tm_slave_multimaster_tag_return
   import tm_shell_pkg::*;
#(
   parameter int unsigned NUM_CREDITS      = 8,
   parameter int unsigned ADDRESS_WIDTH    = 4,
   parameter int unsigned VC_ADDRESS_WIDTH = 2,
   parameter int unsigned WIDTH_DATA_IN    = 36,
   parameter int unsigned WIDTH_DATA_OUT   = 36,
   parameter int unsigned WIDTH_TAG        = 8,
   localparam int unsigned CNT_W = $clog2(NUM_CREDITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid_in,
   output logic                        req_ready_out,
   input  logic [WIDTH_TAG-1:0]        req_tag_in,
   input  logic [ADDRESS_WIDTH-1:0]    req_src_in,
   input  logic [VC_ADDRESS_WIDTH-1:0] req_vc_in,
   input  logic [WIDTH_DATA_IN-1:0]    req_data_in,
   output logic                        req_valid_out,
   input  logic                        req_ready_in,
   output logic [WIDTH_DATA_IN-1:0]    req_data_out,
   input  logic                        resp_valid_in,
   output logic                        resp_ready_out,
   input  logic [WIDTH_DATA_OUT-1:0]   resp_data_in,
   output logic                        resp_valid_out,
   input  logic                        resp_ready_in,
   output logic [WIDTH_DATA_OUT-1:0]   resp_data_out,
   output logic [WIDTH_TAG-1:0]        resp_tag_out,
   output logic [ADDRESS_WIDTH-1:0]    resp_dst_out,
   output logic [VC_ADDRESS_WIDTH-1:0] resp_vc_out,
   output logic [CNT_W-1:0]            outstanding,
   output logic                        err_orphan
);
   tm_ctx_t                     push_ctx_s, head_ctx_s;
   logic                        ctx_full_s, ctx_empty_s;
   logic                        push_s, take_s, pop_s, orphan_s;
   logic                        resp_valid_q, resp_valid_d;
   logic [WIDTH_DATA_OUT-1:0]   resp_data_q, resp_data_d;
   logic [WIDTH_TAG-1:0]        resp_tag_q, resp_tag_d;
   logic [ADDRESS_WIDTH-1:0]    resp_dst_q, resp_dst_d;
   logic [VC_ADDRESS_WIDTH-1:0] resp_vc_q, resp_vc_d;
   logic                        err_orphan_q, err_orphan_d;

   assign req_valid_out  = req_valid_in & ~ctx_full_s;
   assign req_ready_out  = req_ready_in & ~ctx_full_s;
   assign req_data_out   = req_data_in;
   assign push_s         = req_valid_in & req_ready_out;
   assign push_ctx_s     = '{tag: req_tag_in, src: req_src_in, vc: req_vc_in};

   assign resp_ready_out = ~resp_valid_q | resp_ready_in;
   assign take_s         = resp_valid_in & resp_ready_out;
   assign pop_s          = take_s & ~ctx_empty_s;
   assign orphan_s       = take_s & ctx_empty_s;

   tm_ctx_fifo #(
      .DEPTH (NUM_CREDITS),
      .WIDTH (CTX_W)
   ) u_ctx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (push_ctx_s),
      .rdata (head_ctx_s),
      .full  (ctx_full_s),
      .empty (ctx_empty_s),
      .count (outstanding)
   );

   // Output register: load on take, hold under backpressure, drop valid after handshake
   always_comb begin
      resp_valid_d = resp_valid_q;
      resp_data_d  = resp_data_q;
      resp_tag_d   = resp_tag_q;
      resp_dst_d   = resp_dst_q;
      resp_vc_d    = resp_vc_q;
      err_orphan_d = err_orphan_q | orphan_s;
      if (pop_s) begin
         resp_valid_d = 1'b1;
         resp_data_d  = resp_data_in;
         resp_tag_d   = head_ctx_s.tag;
         resp_dst_d   = head_ctx_s.src;
         resp_vc_d    = head_ctx_s.vc;
      end else if (resp_ready_in) begin
         resp_valid_d = 1'b0;
      end else begin
         resp_valid_d = resp_valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_valid_q <= 1'b0;
         resp_data_q  <= {WIDTH_DATA_OUT{1'b0}};
         resp_tag_q   <= {WIDTH_TAG{1'b0}};
         resp_dst_q   <= {ADDRESS_WIDTH{1'b0}};
         resp_vc_q    <= {VC_ADDRESS_WIDTH{1'b0}};
         err_orphan_q <= 1'b0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_tag_q   <= resp_tag_d;
         resp_dst_q   <= resp_dst_d;
         resp_vc_q    <= resp_vc_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   assign resp_valid_out = resp_valid_q;
   assign resp_data_out  = resp_data_q;
   assign resp_tag_out   = resp_tag_q;
   assign resp_dst_out   = resp_dst_q;
   assign resp_vc_out    = resp_vc_q;
   assign err_orphan     = err_orphan_q;
endmodule

// File: tb/tb_tm_slave_multimaster_tag_return.sv
// Directed bench with a context/response scoreboard for the tag-return shell.
module tb_tm_slave_multimaster_tag_return;
   typedef struct packed {
      logic [35:0] data;
      logic [7:0]  tag;
      logic [3:0]  dst;
      logic [1:0]  vc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid_in = 1'b0, req_ready_out, req_valid_out, req_ready_in = 1'b1;
   logic [7:0]  req_tag_in = 8'h00;
   logic [3:0]  req_src_in = 4'h0;
   logic [1:0]  req_vc_in = 2'h0;
   logic [35:0] req_data_in = 36'h0, req_data_out;
   logic        resp_valid_in = 1'b0, resp_ready_out, resp_valid_out, resp_ready_in = 1'b1;
   logic [35:0] resp_data_in = 36'h0, resp_data_out;
   logic [7:0]  resp_tag_out;
   logic [3:0]  resp_dst_out;
   logic [1:0]  resp_vc_out;
   logic [3:0]  outstanding;
   logic        err_orphan;

   int   n_cmp = 0;
   int   n_err = 0;
   logic [13:0] ctx_q[$];
   exp_t        exp_q[$];

   always #5 clk = ~clk;

   tm_slave_multimaster_tag_return dut (
      .clk(clk), .rst(rst),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .req_tag_in(req_tag_in), .req_src_in(req_src_in), .req_vc_in(req_vc_in),
      .req_data_in(req_data_in), .req_valid_out(req_valid_out),
      .req_ready_in(req_ready_in), .req_data_out(req_data_out),
      .resp_valid_in(resp_valid_in), .resp_ready_out(resp_ready_out),
      .resp_data_in(resp_data_in), .resp_valid_out(resp_valid_out),
      .resp_ready_in(resp_ready_in), .resp_data_out(resp_data_out),
      .resp_tag_out(resp_tag_out), .resp_dst_out(resp_dst_out),
      .resp_vc_out(resp_vc_out), .outstanding(outstanding), .err_orphan(err_orphan)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_req(input logic [7:0] tag, input logic [3:0] src,
                           input logic [1:0] vc, input logic [35:0] data);
      int n = 0;
      req_valid_in = 1'b1;
      req_tag_in   = tag;
      req_src_in   = src;
      req_vc_in    = vc;
      req_data_in  = data;
      @(negedge clk);
      while (!req_ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_out) chk("req_accept_timeout", {63'h0, req_ready_out}, 64'h1);
      chk("req_data_pass", {28'h0, req_data_out}, {28'h0, data});
      ctx_q.push_back({tag, src, vc});
      step();
      req_valid_in = 1'b0;
   endtask

   task automatic send_resp(input logic [35:0] data);
      int          n = 0;
      logic [13:0] c;
      resp_valid_in = 1'b1;
      resp_data_in  = data;
      @(negedge clk);
      while (!resp_ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!resp_ready_out) chk("resp_take_timeout", {63'h0, resp_ready_out}, 64'h1);
      if (ctx_q.size() > 0) begin
         c = ctx_q.pop_front();
         exp_q.push_back('{data: data, tag: c[13:6], dst: c[5:2], vc: c[1:0]});
      end
      step();
      resp_valid_in = 1'b0;
   endtask

   // Scoreboard monitor: every output handshake must match the oldest expectation
   always @(negedge clk) begin
      if (rst && resp_valid_out && resp_ready_in) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", {63'h0, resp_valid_out}, 64'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_tag",  {56'h0, resp_tag_out},  {56'h0, e.tag});
            chk("resp_dst",  {60'h0, resp_dst_out},  {60'h0, e.dst});
            chk("resp_vc",   {62'h0, resp_vc_out},   {62'h0, e.vc});
            chk("resp_data", {28'h0, resp_data_out}, {28'h0, e.data});
         end
      end
   end

   initial begin
      exp_t hold_e;
      // 1: reset with request asserted
      rst = 1'b0;
      req_valid_in = 1'b1;
      req_tag_in = 8'hEE;
      repeat (3) step();
      chk("rst_outstanding", {60'h0, outstanding}, 64'h0);
      chk("rst_resp_valid",  {63'h0, resp_valid_out}, 64'h0);
      chk("rst_err_orphan",  {63'h0, err_orphan}, 64'h0);
      chk("rst_resp_tag",    {56'h0, resp_tag_out}, 64'h0);
      chk("rst_resp_data",   {28'h0, resp_data_out}, 64'h0);
      req_valid_in = 1'b0;
      rst = 1'b1;
      step();
      chk("post_rst_outstanding", {60'h0, outstanding}, 64'h0);

      // 2: single round trip
      send_req(8'h2A, 4'd5, 2'd1, 36'hABC);
      chk("rt_outstanding_1", {60'h0, outstanding}, 64'h1);
      repeat (3) step();
      send_resp(36'h123);
      chk("rt_resp_valid", {63'h0, resp_valid_out}, 64'h1);
      chk("rt_outstanding_0", {60'h0, outstanding}, 64'h0);
      repeat (2) step();

      // 3: interleaved masters
      send_req(8'h03, 4'd1, 2'd0, 36'h1);
      send_req(8'h07, 4'd9, 2'd2, 36'h2);
      send_req(8'h01, 4'd4, 2'd3, 36'h3);
      chk("il_outstanding", {60'h0, outstanding}, 64'h3);
      send_resp(36'hA01);
      send_resp(36'hA02);
      send_resp(36'hA03);
      repeat (2) step();

      // 4: full
      for (int i = 0; i < 8; i++) send_req(8'h10 + 8'(i), 4'(i), 2'(i), 36'h100 + 36'(i));
      chk("full_outstanding_8", {60'h0, outstanding}, 64'h8);
      req_valid_in = 1'b1;
      req_tag_in = 8'hFF;
      @(negedge clk);
      chk("full_req_ready", {63'h0, req_ready_out}, 64'h0);
      chk("full_req_valid", {63'h0, req_valid_out}, 64'h0);
      step();
      step();
      chk("full_no_push", {60'h0, outstanding}, 64'h8);
      req_valid_in = 1'b0;
      send_resp(36'h200);
      chk("full_ready_again", {63'h0, req_ready_out}, 64'h1);
      chk("full_outstanding_7", {60'h0, outstanding}, 64'h7);
      for (int i = 1; i < 8; i++) send_resp(36'h200 + 36'(i));
      repeat (2) step();

      // 5: output backpressure
      for (int i = 0; i < 4; i++) send_req(8'h40 + 8'(i), 4'(15 - i), 2'(i), 36'h0);
      resp_ready_in = 1'b0;
      send_resp(36'h300);
      resp_valid_in = 1'b1;
      resp_data_in  = 36'h301;
      hold_e = exp_q[0];
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0 || i == 9) begin
            chk("bp_resp_ready", {63'h0, resp_ready_out}, 64'h0);
            chk("bp_valid_held", {63'h0, resp_valid_out}, 64'h1);
            chk("bp_tag_held",   {56'h0, resp_tag_out},   {56'h0, hold_e.tag});
            chk("bp_data_held",  {28'h0, resp_data_out},  {28'h0, hold_e.data});
            chk("bp_no_pop",     {60'h0, outstanding},    64'h3);
         end
      end
      step();
      resp_ready_in = 1'b1;
      send_resp(36'h301);
      send_resp(36'h302);
      send_resp(36'h303);
      repeat (3) step();
      chk("bp_drained", {60'h0, outstanding}, 64'h0);

      // 6: orphan response
      send_resp(36'h555);
      chk("orphan_flag", {63'h0, err_orphan}, 64'h1);
      chk("orphan_no_valid", {63'h0, resp_valid_out}, 64'h0);
      repeat (3) step();
      chk("orphan_sticky", {63'h0, err_orphan}, 64'h1);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("orphan_cleared", {63'h0, err_orphan}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
